// File: rtl/id_ex_hazard_stage_if.sv
// rtl/id_ex_hazard_stage_if.sv - ID-to-EX bundle: decoded ID fields in, registered EX fields and stall status out
interface id_ex_hazard_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [1:0]        id_ALUOp;
    logic [6:0]        id_Funct7;
    logic [2:0]        id_Funct3;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc;
    logic [5:0]        id_ctrl;
    logic              ex_flush;
    logic              hold;

    logic              ex_valid;
    logic [1:0]        ex_ALUOp;
    logic [6:0]        ex_Funct7;
    logic [2:0]        ex_Funct3;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc;
    logic [5:0]        ex_ctrl;
    logic              id_stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_ALUOp, id_Funct7, id_Funct3, id_rs1, id_rs2, id_rd,
               id_rd1, id_rd2, id_imm, id_pc, id_ctrl, ex_flush, hold,
        input  ex_valid, ex_ALUOp, ex_Funct7, ex_Funct3, ex_rs1, ex_rs2, ex_rd,
               ex_rd1, ex_rd2, ex_imm, ex_pc, ex_ctrl, id_stall, stall_count
    );

    modport slave (
        input  id_valid, id_ALUOp, id_Funct7, id_Funct3, id_rs1, id_rs2, id_rd,
               id_rd1, id_rd2, id_imm, id_pc, id_ctrl, ex_flush, hold,
        output ex_valid, ex_ALUOp, ex_Funct7, ex_Funct3, ex_rs1, ex_rs2, ex_rd,
               ex_rd1, ex_rd2, ex_imm, ex_pc, ex_ctrl, id_stall, stall_count
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use bubble insertion, flush, hold and stall counter
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    id_ex_hazard_stage_if.slave   bus
);
    logic hazard;

    // ex_ctrl[4] is MemRead; rs2 is compared even when the ID instruction does not read it.
    assign hazard = bus.ex_valid & bus.ex_ctrl[4] & (bus.ex_rd != 5'd0) & bus.id_valid &
                    ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

    assign bus.id_stall = bus.hold | (hazard & ~bus.ex_flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_ALUOp    <= 2'b00;
            bus.ex_Funct7   <= 7'd0;
            bus.ex_Funct3   <= 3'd0;
            bus.ex_rs1      <= 5'd0;
            bus.ex_rs2      <= 5'd0;
            bus.ex_rd       <= 5'd0;
            bus.ex_rd1      <= {DATA_W{1'b0}};
            bus.ex_rd2      <= {DATA_W{1'b0}};
            bus.ex_imm      <= {DATA_W{1'b0}};
            bus.ex_pc       <= {DATA_W{1'b0}};
            bus.ex_ctrl     <= 6'd0;
            bus.stall_count <= {CNT_W{1'b0}};
        end else if (!bus.hold) begin
            if (bus.ex_flush || hazard) begin
                // Bubble: all-zero decodes downstream as a side-effect-free ADD.
                bus.ex_valid  <= 1'b0;
                bus.ex_ALUOp  <= 2'b00;
                bus.ex_Funct7 <= 7'd0;
                bus.ex_Funct3 <= 3'd0;
                bus.ex_rs1    <= 5'd0;
                bus.ex_rs2    <= 5'd0;
                bus.ex_rd     <= 5'd0;
                bus.ex_rd1    <= {DATA_W{1'b0}};
                bus.ex_rd2    <= {DATA_W{1'b0}};
                bus.ex_imm    <= {DATA_W{1'b0}};
                bus.ex_pc     <= {DATA_W{1'b0}};
                bus.ex_ctrl   <= 6'd0;
                if (!bus.ex_flush && (bus.stall_count != {CNT_W{1'b1}}))
                    bus.stall_count <= bus.stall_count + CNT_W'(1);
            end else begin
                bus.ex_valid  <= bus.id_valid;
                bus.ex_ALUOp  <= bus.id_ALUOp;
                bus.ex_Funct7 <= bus.id_Funct7;
                bus.ex_Funct3 <= bus.id_Funct3;
                bus.ex_rs1    <= bus.id_rs1;
                bus.ex_rs2    <= bus.id_rs2;
                bus.ex_rd     <= bus.id_rd;
                bus.ex_rd1    <= bus.id_rd1;
                bus.ex_rd2    <= bus.id_rd2;
                bus.ex_imm    <= bus.id_imm;
                bus.ex_pc     <= bus.id_pc;
                bus.ex_ctrl   <= bus.id_ctrl;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb/tb_id_ex_hazard_stage.sv - directed and randomized checks of id_ex_hazard_stage against a pipeline-rule model
module tb_id_ex_hazard_stage;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic          valid;
        logic [1:0]    aluop;
        logic [6:0]    f7;
        logic [2:0]    f3;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [5:0]    ctrl;
    } ex_t;

    localparam logic [5:0] CTRL_LW  = 6'b110110;
    localparam logic [5:0] CTRL_ALU = 6'b100000;

    logic clk;
    logic reset;
    id_ex_hazard_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    id_ex_hazard_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ex_t m;
    int  m_cnt;
    int  checks;
    int  errors;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t id_word();
        ex_t w;
        w.valid = bus.id_valid;  w.aluop = bus.id_ALUOp; w.f7 = bus.id_Funct7; w.f3 = bus.id_Funct3;
        w.rs1 = bus.id_rs1; w.rs2 = bus.id_rs2; w.rd = bus.id_rd;
        w.rd1 = bus.id_rd1; w.rd2 = bus.id_rd2; w.imm = bus.id_imm; w.pc = bus.id_pc;
        w.ctrl = bus.id_ctrl;
        return w;
    endfunction

    function automatic ex_t ex_word();
        ex_t w;
        w.valid = bus.ex_valid;  w.aluop = bus.ex_ALUOp; w.f7 = bus.ex_Funct7; w.f3 = bus.ex_Funct3;
        w.rs1 = bus.ex_rs1; w.rs2 = bus.ex_rs2; w.rd = bus.ex_rd;
        w.rd1 = bus.ex_rd1; w.rd2 = bus.ex_rd2; w.imm = bus.ex_imm; w.pc = bus.ex_pc;
        w.ctrl = bus.ex_ctrl;
        return w;
    endfunction

    // A load sitting in EX whose nonzero destination is named by the ID instruction.
    function automatic bit load_use();
        return m.valid && m.ctrl[4] && (m.rd != 5'd0) && bus.id_valid &&
               ((m.rd == bus.id_rs1) || (m.rd == bus.id_rs2));
    endfunction

    task automatic set_id(input logic v, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [5:0] ctrl);
        bus.id_valid = v;  bus.id_ALUOp = op; bus.id_Funct7 = f7; bus.id_Funct3 = f3;
        bus.id_rs1 = rs1;  bus.id_rs2 = rs2;  bus.id_rd = rd;
        bus.id_rd1 = a;    bus.id_rd2 = b;    bus.id_imm = a ^ 32'h0000_0F0F; bus.id_pc = b + 32'h100;
        bus.id_ctrl = ctrl;
    endtask

    task automatic cycle(input string tag);
        bit lu;
        #1;
        lu = load_use();
        chk({tag, "_stall"}, 200'(bus.id_stall), 200'(bus.hold | (lu & ~bus.ex_flush)));
        if (bus.hold) begin
        end else if (bus.ex_flush) begin
            m = '0;
        end else if (lu) begin
            m = '0;
            m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else begin
            m = id_word();
        end
        @(posedge clk);
        #1;
        chk({tag, "_ex"},  200'(ex_word()),       200'(m));
        chk({tag, "_cnt"}, 200'(bus.stall_count), 200'(m_cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m = '0;
        m_cnt = 0;
        reset = 1'b1;
        bus.ex_flush = 1'b0;
        bus.hold = 1'b0;
        set_id(0, 2'b00, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 6'd0);
        #2;
        chk("rst_ex",    200'(ex_word()),       200'(0));
        chk("rst_cnt",   200'(bus.stall_count), 200'(0));
        chk("rst_stall", 200'(bus.id_stall),    200'(0));
        @(negedge clk);
        reset = 1'b0;

        // SUB reaches EX one edge later.
        set_id(1, 2'b10, 7'b0100000, 3'b000, 5'd1, 5'd2, 5'd5, 32'd7, 32'd3, CTRL_ALU);
        cycle("sub");
        chk("sub_valid", 200'(bus.ex_valid),  200'(1));
        chk("sub_f7",    200'(bus.ex_Funct7), 200'(7'b0100000));
        chk("sub_rd",    200'(bus.ex_rd),     200'(5));
        chk("sub_rd1",   200'(bus.ex_rd1),    200'(7));
        chk("sub_rd2",   200'(bus.ex_rd2),    200'(3));

        // Load-use on rs2: one bubble, then the held instruction loads.
        set_id(1, 2'b00, 7'd0, 3'b010, 5'd1, 5'd0, 5'd6, 32'd40, 32'd0, CTRL_LW);
        cycle("lw1");
        set_id(1, 2'b10, 7'd0, 3'b000, 5'd3, 5'd6, 5'd7, 32'd11, 32'd12, CTRL_ALU);
        cycle("lu_bubble");
        chk("lu_bub_valid", 200'(bus.ex_valid), 200'(0));
        chk("lu_bub_ctrl",  200'(bus.ex_ctrl),  200'(0));
        cycle("lu_load");
        chk("lu_load_rd", 200'(bus.ex_rd),       200'(7));
        chk("lu_cnt1",    200'(bus.stall_count), 200'(1));

        // Flush beats the hazard: no stall, no count.
        set_id(1, 2'b00, 7'd0, 3'b010, 5'd1, 5'd0, 5'd6, 32'd40, 32'd0, CTRL_LW);
        cycle("lw2");
        set_id(1, 2'b10, 7'd0, 3'b000, 5'd3, 5'd6, 5'd7, 32'd11, 32'd12, CTRL_ALU);
        bus.ex_flush = 1'b1;
        cycle("flush_hz");
        bus.ex_flush = 1'b0;
        chk("flush_cnt", 200'(bus.stall_count), 200'(1));

        // Load to x0 never stalls.
        set_id(1, 2'b00, 7'd0, 3'b010, 5'd1, 5'd0, 5'd0, 32'd40, 32'd0, CTRL_LW);
        cycle("lw_x0");
        set_id(1, 2'b10, 7'd0, 3'b000, 5'd0, 5'd0, 5'd8, 32'd21, 32'd22, CTRL_ALU);
        cycle("x0_load");
        chk("x0_rd", 200'(bus.ex_rd), 200'(8));

        // Hold freezes everything while a hazard is pending.
        set_id(1, 2'b00, 7'd0, 3'b010, 5'd1, 5'd0, 5'd6, 32'd40, 32'd0, CTRL_LW);
        cycle("lw3");
        set_id(1, 2'b10, 7'd0, 3'b000, 5'd6, 5'd2, 5'd9, 32'd31, 32'd32, CTRL_ALU);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle("hold");
        chk("hold_cnt", 200'(bus.stall_count), 200'(1));
        bus.hold = 1'b0;
        cycle("hold_bubble");
        cycle("hold_load");
        chk("hold_load_rd", 200'(bus.ex_rd), 200'(9));

        // Random traffic with a small register index space to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 2'($urandom), 7'($urandom), 3'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   32'($urandom), 32'($urandom), 6'($urandom));
            bus.ex_flush = ($urandom_range(0, 7) == 0);
            bus.hold     = ($urandom_range(0, 7) == 0);
            cycle("rnd");
        end
        bus.ex_flush = 1'b0;
        bus.hold = 1'b0;

        // Drive the counter into saturation.
        for (int i = 0; i < 20; i++) begin
            set_id(1, 2'b00, 7'd0, 3'b010, 5'd1, 5'd1, 5'd6, 32'(i), 32'd0, CTRL_LW);
            cycle("sat_lw");
            set_id(1, 2'b10, 7'd0, 3'b000, 5'd6, 5'd2, 5'd3, 32'd1, 32'd2, CTRL_ALU);
            cycle("sat_hz");
        end
        chk("sat_cnt", 200'(bus.stall_count), 200'(4'hF));

        // Asynchronous reset in the middle of a pending hazard.
        set_id(1, 2'b00, 7'd0, 3'b010, 5'd1, 5'd1, 5'd6, 32'd5, 32'd0, CTRL_LW);
        cycle("arst_lw");
        set_id(1, 2'b10, 7'd0, 3'b000, 5'd6, 5'd2, 5'd3, 32'd1, 32'd2, CTRL_ALU);
        #1;
        chk("arst_pre_stall", 200'(bus.id_stall), 200'(1));
        #1;
        reset = 1'b1;
        #1;
        m = '0;
        m_cnt = 0;
        chk("arst_ex",    200'(ex_word()),       200'(0));
        chk("arst_cnt",   200'(bus.stall_count), 200'(0));
        chk("arst_stall", 200'(bus.id_stall),    200'(0));
        @(negedge clk);
        reset = 1'b0;
        cycle("arst_after");
        chk("arst_after_rd", 200'(bus.ex_rd), 200'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection.
- Captures decoded ID-stage fields: ALUOp, Funct7, Funct3, operands, immediate, rd and control bits.
- Presents them registered to the EX stage, where they drive the ALU controller and the ALU.
- Inserts bubbles on load-use hazards and branch flushes, freezes on a global hold, and counts load-use stalls.

Parameters:
DATA_W, 32, width of operand, immediate and PC fields
CNT_W, 32, width of saturating load-use stall counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
id_Funct7  in  7  instr[31:25]
id_Funct3  in  3  instr[14:12]
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_rd1, id_rd2  in  DATA_W each  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc  in  DATA_W  instruction PC
id_ctrl  in  6  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}
ex_flush  in  1  branch/jump taken, resolved in EX
hold  in  1  global pipeline freeze (memory wait)
ex_valid  out  1  EX register holds a real instruction
ex_ALUOp, ex_Funct7, ex_Funct3  out  2/7/3  registered ALU-controller inputs
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices, forwarding unit consumes
ex_rd1, ex_rd2, ex_imm, ex_pc  out  DATA_W each  registered data
ex_ctrl  out  6  registered control, same bit order as id_ctrl
id_stall  out  1  combinational; holds PC and IF/ID when high
stall_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (async, active-high): all ex_* outputs 0, ex_valid 0, stall_count 0.
  - id_stall follows its combinational equation from the reset register state, which is 0 unless hold=1.
- hazard (combinational) = ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - rs2 is compared unconditionally; this is a deliberately conservative rule.
- id_stall = hold | (hazard & ~ex_flush).
- Register update each rising edge, first matching rule wins:
  1. hold: all EX fields keep their value; stall_count unchanged.
  2. ex_flush: bubble loaded.
  3. hazard: bubble loaded; stall_count += 1, saturating at all-ones.
  4. otherwise: all id_* fields loaded; ex_valid <= id_valid.
- Bubble: ex_valid=0, ex_ctrl=0, ex_ALUOp=00, ex_Funct7=0, ex_Funct3=0, ex_rd=0, all other fields 0.
  - The bubble is then decoded downstream as ADD with no side effects.
- Latency: exactly 1 cycle from ID to EX when no stall. A load-use hazard costs exactly 1 bubble.
  - After the bubble, ex_MemRead=0, so hazard deasserts and the held ID instruction loads on the next edge.
- Flush and hazard in the same cycle:
  - Flush wins, the counter does not increment, and id_stall stays low.
  - The wrong-path ID instruction is discarded upstream.
- Hold with flush or hazard: the freeze wins. The flush/hazard condition persists and is acted on in the first cycle hold is low.
- ex_rd = 0 never triggers a hazard, even for a load to x0.
- Reset asserted mid-stall: outputs clear immediately; no stall persists after release.
- No combinational path from id_* data fields to any ex_* output.

Test Plan:
- Reset then id_valid=1, ALUOp=10, Funct3=000, Funct7=0100000, rd=5, rd1=7, rd2=3 (SUB) -> next edge: ex_valid=1, ex_Funct7=0100000, ex_rd=5, ex_rd1=7, ex_rd2=3; id_stall=0.
- EX holds LW (MemRead=1, rd=6), ID instruction has rs2=6 -> id_stall=1 for 1 cycle, then a bubble (ex_valid=0, ex_ctrl=0); next edge loads the ID instruction; stall_count=1.
- Same LW in EX with ex_flush=1 -> id_stall=0, bubble loaded, stall_count unchanged at 1.
- LW rd=0 in EX with ID rs1=0 -> no stall; instruction loads on the next edge.
- hold=1 for 3 cycles with a hazard present -> EX fields and stall_count frozen, id_stall=1. On release: 1 bubble, then the load.
- Preload stall_count=all-ones via repeated hazards (CNT_W=4 build: 16 hazards) -> stays 0xF. Assert reset mid-hazard -> all outputs 0 asynchronously.
